phase_unwrapper_mc: RTL and testbench
=====================================

# phase_unwrapper_mc

Multi-channel, time-interleaved phase unwrapper for the demodulation datapath. It takes a stream of wrapped phase samples in scaled radians from up to N_CHANNELS interleaved sources, for example per-channel CORDIC outputs. Per channel it produces the unwrapped instantaneous frequency (phase step) and an accumulated unwrapped phase. It sits between the CORDIC/phase extraction stage and the decimation/DMA stage, and supersedes the single-channel unwrapper.

## Interface
- DIN_WIDTH, 16, wrapped phase input width; scaled radians, PI = 2^(DIN_WIDTH-3)
- DOUT_WIDTH, 32, accumulated phase width (two's complement)
- N_CHANNELS, 4, interleaved channel count, >= 1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of all channel state and pipeline
- acc_on  in  1  accumulation enable (global)
- s_valid  in  1  input sample strobe; no backpressure
- s_phase  in  DIN_WIDTH  signed wrapped phase
- s_last  in  1  marks last channel of a frame
- m_valid  out  1  output strobe
- m_chan  out  CW = max(1, clog2(N_CHANNELS))  channel index of the output
- m_freq  out  DIN_WIDTH+1  signed unwrapped phase step
- m_phase  out  DOUT_WIDTH  signed accumulated phase of m_chan
- sync_err  out  1  sticky: s_last seen at channel != N_CHANNELS-1
- sat  out  1  sticky: accumulator saturated (see Configuration)

## Operation
- Channel counter: starts at 0 and increments on each s_valid. It wraps to 0 after N_CHANNELS-1, or after any sample with s_last=1.
- If s_last=1 arrives while the counter != N_CHANNELS-1: set sync_err. The sample is still processed on the current channel, and the next sample is channel 0.
- Per-channel state, held in register arrays: prev_phase[DIN_WIDTH], primed bit, acc[DOUT_WIDTH].
- Stage 1: diff = s_phase - prev_phase[ch], computed at DIN_WIDTH+1 bits. Then prev_phase[ch] <= s_phase.
  - If primed[ch]=0, diff is forced to 0 and primed[ch] is set.
- Stage 2: unwrap with TWOPI = 2^(DIN_WIDTH-2).
  - diff > PI: diff - TWOPI.
  - diff < -PI: diff + TWOPI.
  - Otherwise unchanged; exactly +-PI passes unchanged.
- Stage 3: if acc_on, acc[ch] <= acc[ch] + sign-extended unwrapped diff; otherwise acc[ch] holds.
  - m_phase is the post-update value, or the held value when acc_on=0.
  - m_freq is always the unwrapped diff, independent of acc_on.
- clr: zeroes acc, prev_phase, primed and the channel counter, and kills in-flight pipeline valids.
  - A sample presented in the same cycle as clr is dropped.
  - sync_err and sat are cleared by clr.
- rst_n low: all state is cleared as for clr, asynchronously.

## Timing
- Latency: 3 cycles from s_valid to m_valid. Throughput is 1 sample per cycle, for any N_CHANNELS including 1; there is no read-after-write hazard, since state lives in registers.
- Reset values: m_valid=0, m_chan=0, m_freq=0, m_phase=0, sync_err=0, sat=0.
- m_chan, m_freq and m_phase are valid only when m_valid=1. They hold their last values otherwise.
- Gaps in s_valid are allowed; the channel counter does not advance on idle cycles.
- clr at cycle t: m_valid=0 for cycles t+1..t+3. The first post-clr sample is channel 0 with m_freq=0.

## Configuration
- PHASE_UNWRAPPER_SAT_EN defined: the accumulator saturates at 2^(DOUT_WIDTH-1)-1 or -2^(DOUT_WIDTH-1), and sets sat.
- Not defined: the accumulator wraps modulo 2^DOUT_WIDTH, and sat is tied 0.

## Structure
- Package phase_unwrapper_pkg holds:
  - functions pi_scaled(w) and twopi_scaled(w);
  - the channel-width function chan_w(n);
  - the stage-valid/channel pipeline record typedef.
- Sub-module phase_diff_unwrap: registered stage 2, i.e. the diff-to-unwrapped-diff compare/add. It is reusable by other unwrappers.

## Test plan
- N=1, DIN=16, phases 0, 8000, -8000, -8000 -> m_freq 0, 8000, 384, 0; m_phase 0, 8000, 8384, 8384.
- N=1, boundaries:
  - 0 then 8192 -> m_freq 8192;
  - then 0 again, then 8193 -> m_freq -8191;
  - 0 then -8193 -> m_freq +8191.
- N=4, frames with s_last on ch3 -> m_chan 0..3 repeating, sync_err=0. Then s_last on ch1 -> sync_err=1, and the next m_chan=0.
- acc_on low for 3 samples of step 1000 -> m_freq=1000 each, m_phase constant. Re-enable -> accumulation resumes from the held value.
- DOUT=16, N=1, steps of +8000 starting at 0:
  - macro defined -> m_phase reaches 32000, then stays at 32767, sat=1;
  - macro undefined -> 32000 then -25536, sat=0.
- Mid-stream clr, and separately an async rst_n pulse -> outputs zero, no m_valid for 3 cycles, next sample is ch0 with m_freq=0 and m_phase=0.

Source files
------------

// File: rtl/phase_unwrapper_pkg.sv
// rtl/phase_unwrapper_pkg.sv - scaling helpers, channel width and pipeline record for the phase unwrappers
package phase_unwrapper_pkg;

    // Widest channel index carried by the pipeline record (up to 256 channels)
    localparam int CHAN_MAX_W = 8;

    // PI in scaled radians for a w-bit wrapped phase
    function automatic int pi_scaled(input int w);
        return 1 << (w - 3);
    endfunction

    // 2*PI in scaled radians for a w-bit wrapped phase
    function automatic int twopi_scaled(input int w);
        return 1 << (w - 2);
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Stage-valid plus channel tag travelling alongside the datapath
    typedef struct packed {
        logic                  vld;
        logic [CHAN_MAX_W-1:0] chan;
    } pipe_rec_t;

endpackage

// File: rtl/phase_diff_unwrap.sv
// rtl/phase_diff_unwrap.sv - registered fold of a raw phase difference into [-PI, +PI]
module phase_diff_unwrap
    import phase_unwrapper_pkg::*;
#(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic signed [W:0] diff,
    output logic signed [W:0] unwrapped
);

    localparam int PI_I    = pi_scaled(W);
    localparam int TWOPI_I = twopi_scaled(W);
    localparam logic signed [W:0] PI    = (W + 1)'(PI_I);
    localparam logic signed [W:0] TWOPI = (W + 1)'(TWOPI_I);

    logic signed [W:0] corr;

    // Single-step correction; exactly +PI and -PI pass through untouched
    always_comb begin
        corr = diff;
        if (diff > PI) begin
            corr = diff - TWOPI;
        end else if (diff < -PI) begin
            corr = diff + TWOPI;
        end
    end

    // Register the corrected difference when the upstream stage holds a sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unwrapped <= '0;
        end else if (en) begin
            unwrapped <= corr;
        end
    end

endmodule

// File: rtl/phase_unwrapper_mc.sv
// rtl/phase_unwrapper_mc.sv - multi-channel interleaved phase unwrapper; PHASE_UNWRAPPER_SAT_EN selects saturating accumulators
module phase_unwrapper_mc
    import phase_unwrapper_pkg::*;
#(
    parameter  int DIN_WIDTH  = 16,
    parameter  int DOUT_WIDTH = 32,
    parameter  int N_CHANNELS = 4,
    localparam int CW         = chan_w(N_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         acc_on,
    input  logic                         s_valid,
    input  logic signed [DIN_WIDTH-1:0]  s_phase,
    input  logic                         s_last,
    output logic                         m_valid,
    output logic [CW-1:0]                m_chan,
    output logic signed [DIN_WIDTH:0]    m_freq,
    output logic signed [DOUT_WIDTH-1:0] m_phase,
    output logic                         sync_err,
    output logic                         sat
);

    // State arrays are sized to the full index range so any CW-bit index is legal
    localparam int NSLOT = 1 << CW;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CHANNELS - 1);

    logic [CW-1:0]                ch_cnt;
    logic signed [DIN_WIDTH-1:0]  prev_phase [NSLOT];
    logic [NSLOT-1:0]             primed;
    logic signed [DOUT_WIDTH-1:0] acc [NSLOT];

    pipe_rec_t                    s1_rec;
    pipe_rec_t                    s2_rec;
    logic signed [DIN_WIDTH:0]    raw_diff;
    logic signed [DIN_WIDTH:0]    s1_diff;
    logic signed [DIN_WIDTH:0]    s2_diff;
    logic signed [DIN_WIDTH-1:0]  cur_prev;
    logic                         last_chan;
    logic [CW-1:0]                s2_ch;
    logic signed [DOUT_WIDTH-1:0] acc_cur;
    logic signed [DOUT_WIDTH-1:0] acc_next;

    // Channel tags above CW are always zero; fold them so every record bit is consumed
    logic unused_chan_bits;
    assign unused_chan_bits = ^s2_rec.chan;

    assign last_chan = (ch_cnt == LAST_CH);
    assign s2_ch     = s2_rec.chan[CW-1:0];

    // Stage 1 difference against the channel's previous phase; first sample after clear reads as zero
    always_comb begin
        cur_prev = prev_phase[ch_cnt];
        raw_diff = {s_phase[DIN_WIDTH-1], s_phase} - {cur_prev[DIN_WIDTH-1], cur_prev};
        if (!primed[ch_cnt]) begin
            raw_diff = '0;
        end
    end

    // Stage 1 register: channel counter, per-channel history, framing check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt   <= '0;
            primed   <= '0;
            s1_rec   <= '0;
            s1_diff  <= '0;
            sync_err <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                prev_phase[i] <= '0;
            end
        end else if (clr) begin
            ch_cnt   <= '0;
            primed   <= '0;
            s1_rec   <= '0;
            s1_diff  <= '0;
            sync_err <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                prev_phase[i] <= '0;
            end
        end else begin
            s1_rec.vld <= s_valid;
            if (s_valid) begin
                s1_rec.chan        <= CHAN_MAX_W'(ch_cnt);
                s1_diff            <= raw_diff;
                prev_phase[ch_cnt] <= s_phase;
                primed[ch_cnt]     <= 1'b1;
                ch_cnt             <= (s_last || last_chan) ? '0 : ch_cnt + CW'(1);
                if (s_last && !last_chan) begin
                    sync_err <= 1'b1;
                end
            end
        end
    end

    // Stage 2 datapath: wrap correction
    phase_diff_unwrap #(
        .W(DIN_WIDTH)
    ) u_unwrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (s1_rec.vld),
        .diff      (s1_diff),
        .unwrapped (s2_diff)
    );

    // Stage 2 control: carry valid and channel alongside the unwrap register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_rec <= '0;
        end else if (clr) begin
            s2_rec <= '0;
        end else begin
            s2_rec <= s1_rec;
        end
    end

`ifdef PHASE_UNWRAPPER_SAT_EN
    // Sum is formed wide enough that neither operand can overflow before clamping
    localparam int SW = ((DOUT_WIDTH > DIN_WIDTH + 1) ? DOUT_WIDTH : DIN_WIDTH + 1) + 1;
    localparam logic signed [SW-1:0] ACC_MAX = SW'((longint'(1) << (DOUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

    logic signed [SW-1:0] acc_sum;
    logic                 acc_ovf;
    logic                 sat_r;

    // Stage 3 next accumulator value, clamped to the output range
    always_comb begin
        acc_cur  = acc[s2_ch];
        acc_sum  = SW'(acc_cur) + SW'(s2_diff);
        acc_ovf  = 1'b0;
        acc_next = acc_sum[DOUT_WIDTH-1:0];
        if (acc_sum > ACC_MAX) begin
            acc_next = ACC_MAX[DOUT_WIDTH-1:0];
            acc_ovf  = 1'b1;
        end else if (acc_sum < ACC_MIN) begin
            acc_next = ACC_MIN[DOUT_WIDTH-1:0];
            acc_ovf  = 1'b1;
        end
    end

    // Sticky saturation flag, raised only when a clamped value is actually committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else if (clr) begin
            sat_r <= 1'b0;
        end else if (s2_rec.vld && acc_on && acc_ovf) begin
            sat_r <= 1'b1;
        end
    end

    assign sat = sat_r;
`else
    // Stage 3 next accumulator value, wrapping modulo the output width
    always_comb begin
        acc_cur  = acc[s2_ch];
        acc_next = acc_cur + DOUT_WIDTH'(s2_diff);
    end

    assign sat = 1'b0;
`endif

    // Stage 3 register: accumulate and present the result; outputs hold between samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_chan  <= '0;
            m_freq  <= '0;
            m_phase <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                acc[i] <= '0;
            end
        end else if (clr) begin
            m_valid <= 1'b0;
            m_chan  <= '0;
            m_freq  <= '0;
            m_phase <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                acc[i] <= '0;
            end
        end else begin
            m_valid <= s2_rec.vld;
            if (s2_rec.vld) begin
                m_chan <= s2_ch;
                m_freq <= s2_diff;
                if (acc_on) begin
                    acc[s2_ch] <= acc_next;
                    m_phase    <= acc_next;
                end else begin
                    m_phase <= acc_cur;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_unwrapper_mc.sv
// tb/tb_phase_unwrapper_mc.sv - scoreboard bench for phase_unwrapper_mc (4-channel/32-bit and 1-channel/16-bit instances)
module tb_phase_unwrapper_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        acc_on;
    logic        s_valid;
    logic signed [15:0] s_phase;
    logic        s_last;

    logic        m_valid_a, m_valid_b;
    logic [1:0]  m_chan_a;
    logic [0:0]  m_chan_b;
    logic signed [16:0] m_freq_a, m_freq_b;
    logic signed [31:0] m_phase_a;
    logic signed [15:0] m_phase_b;
    logic        sync_err_a, sync_err_b, sat_a, sat_b;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phase_unwrapper_mc #(.DIN_WIDTH(16), .DOUT_WIDTH(32), .N_CHANNELS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc_on(acc_on),
        .s_valid(s_valid), .s_phase(s_phase), .s_last(s_last),
        .m_valid(m_valid_a), .m_chan(m_chan_a), .m_freq(m_freq_a), .m_phase(m_phase_a),
        .sync_err(sync_err_a), .sat(sat_a)
    );

    phase_unwrapper_mc #(.DIN_WIDTH(16), .DOUT_WIDTH(16), .N_CHANNELS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc_on(acc_on),
        .s_valid(s_valid), .s_phase(s_phase), .s_last(s_last),
        .m_valid(m_valid_b), .m_chan(m_chan_b), .m_freq(m_freq_b), .m_phase(m_phase_b),
        .sync_err(sync_err_b), .sat(sat_b)
    );

    typedef struct {
        int     cyc;
        int     chan;
        longint freq;
        longint phase;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int     m_prev   [2][4];
    bit     m_primed [2][4];
    longint m_acc    [2][4];
    int     m_cnt    [2];
    bit     m_serr   [2];
    bit     m_sat    [2];

    function automatic int nch(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int dw(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_serr[i] = 0;
            m_sat[i]  = 0;
            for (int c = 0; c < 4; c++) begin
                m_prev[i][c]   = 0;
                m_primed[i][c] = 0;
                m_acc[i][c]    = 0;
            end
        end
    endtask

    // Reference behaviour: unwrap a step into [-pi, pi], accumulate per channel
    task automatic model_step(input int i, input int ph, input bit last);
        int     ch;
        int     d;
        longint v;
        longint lim;
        exp_t   e;
        ch = m_cnt[i];
        if (last && ch != nch(i) - 1) m_serr[i] = 1;
        d = m_primed[i][ch] ? ph - m_prev[i][ch] : 0;
        m_prev[i][ch]   = ph;
        m_primed[i][ch] = 1;
        if (d > 8192) d -= 16384;
        else if (d < -8192) d += 16384;
        m_cnt[i] = (last || ch == nch(i) - 1) ? 0 : ch + 1;
        if (acc_on) begin
            v   = m_acc[i][ch] + d;
            lim = longint'(1) << (dw(i) - 1);
`ifdef PHASE_UNWRAPPER_SAT_EN
            if (v > lim - 1) begin
                v = lim - 1;
                m_sat[i] = 1;
            end else if (v < -lim) begin
                v = -lim;
                m_sat[i] = 1;
            end
`else
            v = ((v + lim) % (2 * lim) + 2 * lim) % (2 * lim) - lim;
`endif
            m_acc[i][ch] = v;
        end
        e.cyc   = cyc;
        e.chan  = ch;
        e.freq  = d;
        e.phase = m_acc[i][ch];
        if (i == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic issue(input int ph, input bit last);
        logic signed [15:0] p16;
        p16     = 16'(ph);
        s_valid = 1'b1;
        s_phase = p16;
        s_last  = last;
        model_step(0, int'(p16), last);
        model_step(1, int'(p16), last);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Sample with s_last placed on the final channel of the 4-channel frame
    task automatic issue_f(input int ph);
        issue(ph, m_cnt[0] == 3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle(5);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_sync_err_a"}, sync_err_a, m_serr[0]);
        chk({tag, "_sync_err_b"}, sync_err_b, m_serr[1]);
        chk({tag, "_sat_a"}, sat_a, m_sat[0]);
        chk({tag, "_sat_b"}, sat_b, m_sat[1]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_valid_a"}, m_valid_a, 0);
        chk({tag, "_m_chan_a"}, m_chan_a, 0);
        chk({tag, "_m_freq_a"}, m_freq_a, 0);
        chk({tag, "_m_phase_a"}, m_phase_a, 0);
        chk({tag, "_m_valid_b"}, m_valid_b, 0);
        chk({tag, "_m_freq_b"}, m_freq_b, 0);
        chk({tag, "_m_phase_b"}, m_phase_b, 0);
        chk_flags(tag);
    endtask

    // Synchronous clear with a sample presented in the same cycle (that sample must vanish)
    task automatic do_clr();
        int t;
        t       = cyc;
        clr     = 1'b1;
        s_valid = 1'b1;
        s_phase = 16'($urandom);
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        clr     = 1'b0;
        s_valid = 1'b0;
        while (qa.size() > 0 && qa[$].cyc >= t - 2) void'(qa.pop_back());
        while (qb.size() > 0 && qb[$].cyc >= t - 2) void'(qb.pop_back());
        model_clear();
        chk_zero("clr");
        chk("clr_q_a_empty", qa.size(), 0);
        chk("clr_q_b_empty", qb.size(), 0);
    endtask

    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        model_clear();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_phase();
        int b;
        b = int'($urandom_range(0, 6));
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 65535));
        case (b)
            0: return 0;
            1: return 8192;
            2: return -8192;
            3: return 8193;
            4: return -8193;
            5: return 32767;
            default: return -32768;
        endcase
    endfunction

    task automatic mon_pop(input int i, input longint chan, input longint freq, input longint phase);
        exp_t e;
        string nm;
        nm = (i == 0) ? "a" : "b";
        if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_unexpected_valid: got m_valid=1, expected no output (t=%0t)", nm, $time);
        end else begin
            e = (i == 0) ? qa.pop_front() : qb.pop_front();
            chk({nm, "_latency"}, cyc - e.cyc, 3);
            chk({nm, "_m_chan"}, chan, e.chan);
            chk({nm, "_m_freq"}, freq, e.freq);
            chk({nm, "_m_phase"}, phase, e.phase);
        end
    endtask

    // Monitor: every output strobe is matched against the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_valid_a) mon_pop(0, longint'(m_chan_a), longint'(m_freq_a), longint'(m_phase_a));
            if (m_valid_b) mon_pop(1, longint'(m_chan_b), longint'(m_freq_b), longint'(m_phase_b));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        acc_on  = 1'b1;
        s_valid = 1'b0;
        s_phase = '0;
        s_last  = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_zero("reset");

        // Basic unwrap and accumulate
        issue_f(0);
        issue_f(8000);
        issue_f(-8000);
        issue_f(-8000);
        drain();

        // Boundaries around +-PI
        do_clr();
        issue_f(0);
        issue_f(8192);
        issue_f(0);
        issue_f(8193);
        issue_f(0);
        issue_f(-8193);
        issue_f(0);
        issue_f(-8192);
        drain();

        // Clean framing, then an early s_last
        do_clr();
        for (int k = 0; k < 12; k++) issue_f(rand_phase());
        drain();
        chk_flags("framed");
        issue(rand_phase(), 1'b0);
        issue(rand_phase(), 1'b1);
        issue(rand_phase(), 1'b0);
        drain();
        chk_flags("early_last");

        // Accumulation hold and resume
        do_clr();
        issue_f(0);
        issue_f(1000);
        drain();
        acc_on = 1'b0;
        issue_f(2000);
        issue_f(3000);
        issue_f(4000);
        drain();
        acc_on = 1'b1;
        issue_f(5000);
        issue_f(6000);
        drain();

        // Steady +8000 steps drive the 16-bit accumulator past full scale
        do_clr();
        for (int k = 0; k < 8; k++) issue_f(((k * 8000 + 8192) % 16384) - 8192);
        drain();
        chk_flags("overflow");

        // Mid-stream clear and asynchronous reset pulse
        for (int k = 0; k < 6; k++) issue_f(rand_phase());
        do_clr();
        idle(3);
        issue_f(1234);
        issue_f(2234);
        drain();
        for (int k = 0; k < 6; k++) issue_f(rand_phase());
        reset_pulse();
        idle(3);
        issue_f(-777);
        issue_f(-1777);
        drain();

        // Randomized bursts with gaps, stray s_last and occasional clears
        for (int b = 0; b < 20; b++) begin
            acc_on = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 20; k++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r == 0) do_clr();
                else if (r < 4) idle(1);
                else if (r == 4) issue(rand_phase(), 1'b1);
                else issue_f(rand_phase());
            end
            drain();
            chk_flags("burst");
        end

        drain();
        chk_flags("final");
        chk("final_q_a_empty", qa.size(), 0);
        chk("final_q_b_empty", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
